// File: rtl/ccff_bitstream_loader.sv
// Serial feeder for the FPGA configuration chain: words in over valid/ready, bits out LSB-first on ccff_head.
// Optional tail check of the all-zero chain on the first load after reset: define CCFF_TAIL_CHECK_EN.
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 64,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  chain_err
);

  // state  | meaning
  // S_IDLE | waiting for start after reset
  // S_LOAD | accepting words and shifting bits into the chain
  // S_DONE | CHAIN_LENGTH shifts issued; waiting for the next start

  localparam int BW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] sreg, sreg_nxt;
  logic [BW-1:0]         bits_left, bits_nxt, word_bits;
  logic [CNT_WIDTH-1:0]  shift_cnt, load_cnt, load_cnt_nxt, remaining;
  logic                  accept, issue, cur_bit, start_ok, cnt_full;

  assign start_ok = start && (state != S_LOAD);
  assign cnt_full = (shift_cnt == CNT_WIDTH'(CHAIN_LENGTH));

  always_ff @(posedge prog_clk) begin
    if (pReset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_LOAD;
      S_LOAD:  if (cnt_full) state_nxt = S_DONE;
      S_DONE:  if (start)    state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_LOAD);
    done      = (state == S_DONE);
    cfg_ready = (state == S_LOAD) && (bits_left <= BW'(1)) &&
                (load_cnt < CNT_WIDTH'(CHAIN_LENGTH));
  end

  // The last word of a load only contributes the bits still owed to the chain.
  always_comb begin
    remaining = CNT_WIDTH'(CHAIN_LENGTH) - load_cnt;
    word_bits = (int'(remaining) >= WORD_WIDTH) ? BW'(WORD_WIDTH) : BW'(remaining);
  end

  // An empty register forwards cfg_data[0] directly so the first bit leaves the cycle it is accepted.
  always_comb begin
    accept       = cfg_ready && cfg_valid;
    issue        = busy && ((bits_left != '0) || accept);
    cur_bit      = (bits_left != '0) ? sreg[0] : cfg_data[0];
    sreg_nxt     = sreg;
    bits_nxt     = bits_left;
    load_cnt_nxt = load_cnt;
    if (accept) begin
      load_cnt_nxt = load_cnt + CNT_WIDTH'(word_bits);
      if (bits_left == '0) begin
        sreg_nxt = cfg_data >> 1;
        bits_nxt = word_bits - BW'(1);
      end else begin
        sreg_nxt = cfg_data;
        bits_nxt = word_bits;
      end
    end else if (issue) begin
      sreg_nxt = sreg >> 1;
      bits_nxt = bits_left - BW'(1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sreg          <= '0;
      bits_left     <= '0;
      load_cnt      <= '0;
      shift_cnt     <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else if (start_ok) begin
      sreg          <= '0;
      bits_left     <= '0;
      load_cnt      <= '0;
      shift_cnt     <= '0;
      ccff_shift_en <= 1'b0;
    end else begin
      sreg          <= sreg_nxt;
      bits_left     <= bits_nxt;
      load_cnt      <= load_cnt_nxt;
      ccff_shift_en <= issue;
      if (issue) begin
        ccff_head <= cur_bit;
        shift_cnt <= shift_cnt + CNT_WIDTH'(1);
      end
      if (busy && cnt_full) begin
        sreg      <= '0;
        bits_left <= '0;
      end
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  logic first_load;

  // Tail is sampled on the same edge that applies the shift it belongs to.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_err  <= 1'b0;
      first_load <= 1'b1;
    end else if (start_ok) begin
      chain_err <= 1'b0;
    end else begin
      if (first_load && ccff_shift_en && ccff_tail) chain_err <= 1'b1;
      if (busy && cnt_full) first_load <= 1'b0;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign chain_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader at CHAIN_LENGTH=20, WORD_WIDTH=8 (tail check follows CCFF_TAIL_CHECK_EN).
module tb_ccff_bitstream_loader;
  localparam int WW = 8;
  localparam int CL = 20;
  localparam logic [19:0] EXP_SEQ = 20'hF3CA5;
`ifdef CCFF_TAIL_CHECK_EN
  localparam bit TAIL_CHK = 1'b1;
`else
  localparam bit TAIL_CHK = 1'b0;
`endif

  logic          prog_clk = 1'b0;
  logic          pReset, start, cfg_valid, cfg_ready, ccff_head, ccff_shift_en;
  logic          ccff_tail, busy, done, chain_err;
  logic [WW-1:0] cfg_data;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy),
    .done(done), .chain_err(chain_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int gap;
    int start_at;
    int tail_at;
    int exp_bubbles;
  } vec_t;

  vec_t          vecs[5];
  logic [WW-1:0] words[4];

  int          en_cnt, first_en, last_en, done_cyc, acc0, words_acc, busy_bad;
  logic [31:0] seq;
  logic        err_at_done, busy_at_done;
  bit          timed_out;

  task automatic do_reset();
    pReset = 1'b1; start = 1'b0; cfg_valid = 1'b0; ccff_tail = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    pReset = 1'b0;
  endtask

  // gap: cycles of cfg_ready=1 during which valid is held low after each accepted word.
  task automatic run_load(input int gap, input int start_at, input int tail_at, input int abort_at);
    int widx = 0;
    int gap_left = 0;
    bit will_acc = 1'b0;
    en_cnt = 0; first_en = -1; last_en = -1; done_cyc = -1; acc0 = -1;
    words_acc = 0; busy_bad = 0; seq = '0; timed_out = 1'b1;
    err_at_done = 1'b0; busy_at_done = 1'b1;
    start = 1'b1; cfg_valid = 1'b0; ccff_tail = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge prog_clk);
      #1;
      start     = (cyc == start_at);
      ccff_tail = 1'b0;
      if (will_acc) begin
        words_acc++;
        widx++;
        gap_left = gap;
      end
      if (ccff_shift_en) begin
        if (!busy) busy_bad++;
        if (en_cnt < 32) seq[en_cnt] = ccff_head;
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (en_cnt == tail_at) ccff_tail = 1'b1;
      end
      if (done) begin
        done_cyc = cyc; err_at_done = chain_err; busy_at_done = busy; timed_out = 1'b0;
        break;
      end
      if (abort_at > 0 && en_cnt == abort_at) begin
        timed_out = 1'b0;
        break;
      end
      cfg_data = words[(widx > 3) ? 3 : widx];
      if (widx >= 3) cfg_valid = 1'b1;
      else if (gap_left > 0) begin
        cfg_valid = 1'b0;
        if (cfg_ready) gap_left--;
      end else cfg_valid = 1'b1;
      will_acc = cfg_valid && cfg_ready;
      if (will_acc && acc0 < 0) acc0 = cyc;
    end
    start = 1'b0; cfg_valid = 1'b0; ccff_tail = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  32'(cfg_ready),     0);
    check({tag, "_head"},   32'(ccff_head),     0);
    check({tag, "_en"},     32'(ccff_shift_en), 0);
    check({tag, "_busy"},   32'(busy),          0);
    check({tag, "_done"},   32'(done),          0);
    check({tag, "_err"},    32'(chain_err),     0);
  endtask

  task automatic check_full_load(input string tag, input int exp_bubbles, input bit exp_err);
    check({tag, "_finished"}, 32'(timed_out), 0);
    check({tag, "_en_count"}, en_cnt, CL);
    check({tag, "_head_seq"}, seq, 32'(EXP_SEQ));
    check({tag, "_bubbles"},  (last_en - first_en + 1) - en_cnt, exp_bubbles);
    check({tag, "_done_lag"}, done_cyc - last_en, 1);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
    check({tag, "_latency"},  first_en - acc0, 1);
    check({tag, "_words_acc"}, words_acc, 3);
    check({tag, "_en_wo_busy"}, busy_bad, 0);
    check({tag, "_chain_err"}, 32'(err_at_done), 32'(exp_err));
  endtask

  initial begin
    vecs[0] = '{0, -1, 0, 0};
    vecs[1] = '{4, -1, 0, 6};
    vecs[2] = '{1, -1, 0, 0};
    vecs[3] = '{0,  6, 0, 0};
    vecs[4] = '{0, 15, 5, 0};
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F; words[3] = 8'hFF;
    cfg_data = '0;

    do_reset();
    check_all_zero("reset");
    cfg_valid = 1'b1; cfg_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge prog_clk);
      #1;
      check("idle_ready", 32'(cfg_ready), 0);
    end
    cfg_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      run_load(vecs[v].gap, vecs[v].start_at, vecs[v].tail_at, 0);
      check_full_load($sformatf("v%0d", v), vecs[v].exp_bubbles,
                      TAIL_CHK && (vecs[v].tail_at != 0));
    end

    cfg_valid = 1'b1; cfg_data = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      @(posedge prog_clk);
      #1;
      check("done_ready", 32'(cfg_ready), 0);
      check("done_hold", 32'(done), 1);
      check("done_en", 32'(ccff_shift_en), 0);
      check("done_err_sticky", 32'(chain_err), 32'(TAIL_CHK));
    end
    cfg_valid = 1'b0;
    start = 1'b1;
    @(posedge prog_clk);
    #1;
    start = 1'b0;
    check("restart_err_clr", 32'(chain_err), 0);
    check("restart_busy", 32'(busy), 1);

    do_reset();
    run_load(0, -1, 0, 9);
    check("abort_shifts", en_cnt, 9);
    pReset = 1'b1;
    @(posedge prog_clk);
    #1;
    pReset = 1'b0;
    check_all_zero("abort");
    run_load(0, -1, 0, 0);
    check_full_load("reload", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain feeder that sits directly upstream of the first I/O grid tile's `ccff_head`.
- Accepts configuration words over a valid/ready stream, serializes them LSB-first and drives `ccff_head`.
- Produces a shift-enable for the external prog_clk gating cell, so the chain advances only when a valid bit is presented.
- Counts exactly CHAIN_LENGTH shifts, then reports done.

Parameters:
- WORD_WIDTH, 8, width of incoming configuration words.
- CHAIN_LENGTH, 64, total configuration flops in the downstream chain (number of shifts per load).
- CNT_WIDTH, $clog2(CHAIN_LENGTH+1), width of the shift counter.

Ports:
- prog_clk  input  1  programming clock; sole clock of the block.
- pReset  input  1  synchronous, active-high reset, sampled on rising prog_clk.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  block accepts cfg_data this cycle.
- cfg_data  input  WORD_WIDTH  configuration word; bit 0 is shifted first.
- ccff_head  output  1  serial bit into the chain.
- ccff_shift_en  output  1  chain advances on the next prog_clk edge only when 1.
- ccff_tail  input  1  serial output of the last chain flop.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- chain_err  output  1  sticky tail-check failure (optional feature only; tied 0 otherwise).

Behaviour:
- Clocking and reset: one clock, prog_clk. pReset is synchronous and active-high.
- Reset values: cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, chain_err=0. State=IDLE, counter=0, shift register empty.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 moves to LOAD next cycle, clears the counter and clears chain_err.
  - LOAD: moves to DONE in the cycle after the CHAIN_LENGTH-th shift has been issued.
  - DONE: start=1 moves to LOAD, with the same clears as from IDLE. done holds until then.
- start during LOAD is ignored.
- Datapath: one shift register (WORD_WIDTH bits) plus a bit-remaining count.
  - cfg_ready=1 only in LOAD, when the shift register is empty or its last bit is being issued this cycle, and fewer than CHAIN_LENGTH bits have been loaded.
  - cfg_ready is combinational from state and count. It must not depend on cfg_valid.
- Each cycle in LOAD with a bit available:
  - ccff_head is registered to the current LSB and ccff_shift_en is registered 1.
  - The register shifts right and the counter increments.
  - ccff_head and ccff_shift_en change together, one cycle after the word is accepted. Latency from accept to first shift_en is 1 cycle.
- Underrun (no bit available in LOAD): ccff_shift_en=0 and ccff_head holds its value. This is not an error; the chain simply stalls.
- Final word: if CHAIN_LENGTH mod WORD_WIDTH ≠ 0, only the low (CHAIN_LENGTH mod WORD_WIDTH) bits are shifted. The rest are discarded, and the shift register is emptied once the counter reaches CHAIN_LENGTH.
- Outside LOAD, ccff_shift_en=0 in every cycle.
- Back-to-back words with cfg_valid held high produce contiguous shift_en=1 with no bubble.
- pReset mid-load: all state returns to reset values on the next edge. The partially shifted chain is not re-cleared by this block.

Optional Feature:
- Macro: CCFF_TAIL_CHECK_EN.
- Defined:
  - The downstream chain is all-zero after pReset, so for the first CHAIN_LENGTH shifts ccff_tail must read 0 on every cycle in which ccff_shift_en=1. ccff_tail is sampled at the same edge the shift is applied.
  - Any 1 sets chain_err, which stays set until pReset or the next start.
  - The check is active only for the first load after pReset; later loads skip it.
- Undefined: chain_err is tied 0 and ccff_tail is unused.

Test Plan:
- CHAIN_LENGTH=20, WORD_WIDTH=8: pReset 2 cycles, start, then words 0xA5, 0x3C, 0x0F with valid held -> head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. shift_en high for exactly 20 contiguous cycles. done=1 the cycle after, busy=0.
- Same load with valid dropped for 3 cycles between words -> shift_en low 3 cycles, total shift_en count still 20, identical head bit sequence.
- pReset asserted after 9 shifts -> next cycle all outputs 0 and state IDLE. A new start reloads from bit 0 with the count restarting at 0.
- start pulses during LOAD -> ignored, done after exactly 20 shifts. cfg_valid in IDLE or DONE -> cfg_ready stays 0.
- CCFF_TAIL_CHECK_EN defined: drive tail=1 on the 5th shift cycle -> chain_err=1 and stays set through DONE. A second start clears it.
- After done, the third word's upper 4 bits (0x0_) are never shifted, and a 4th offered word is not accepted (cfg_ready=0).
